td4_prog_mem: RTL
=================

Name: td4_prog_mem

Overview:
- Writable 16 x 8 program memory serving the TD4 CPU's instruction-fetch port.
- The CPU drives a 4-bit address and receives the 8-bit instruction combinationally.
- A byte-stream load port (valid/ready) refills all 16 words.
- During a load the block holds the CPU in reset via cpu_n_reset, then releases it so the CPU restarts from address 0 with the new program.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W words.
- DATA_W, 8, instruction width ({op[3:0], im[3:0]}).

Ports:
- clk  input  1  clock; all state updates on posedge.
- n_reset  input  1  asynchronous, active-low reset.
- address  input  ADDR_W  CPU fetch address (CPU program counter).
- instr  output  DATA_W  mem[address], combinational read.
- load_start  input  1  single-cycle request to begin a program load.
- wr_valid  input  1  wr_data valid.
- wr_data  input  DATA_W  program byte, word 0 first.
- wr_ready  output  1  block accepts a byte this cycle.
- cpu_n_reset  output  1  active-low reset to the CPU; registered.
- busy  output  1  load in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when the load completes successfully.
- err  output  1  checksum failure, sticky (see Optional Feature).

Behaviour:
- Reset (asynchronous, n_reset=0):
  - state=IDLE, wr_ptr=0.
  - All mem words = 8'h00.
  - cpu_n_reset=0, wr_ready=0, busy=0, done=0, err=0.
- First posedge after n_reset deasserts, in IDLE: cpu_n_reset goes to 1.
- Read path:
  - instr = mem[address] at all times, including during a load.
  - A write at posedge is visible on instr after that edge.
- States:
  - IDLE: wr_ready=0, cpu_n_reset=1. load_start=1 -> LOAD, wr_ptr<=0, cpu_n_reset<=0, err<=0.
  - LOAD: wr_ready=1, cpu_n_reset=0. On wr_valid&wr_ready: mem[wr_ptr]<=wr_data, wr_ptr<=wr_ptr+1. The beat with wr_ptr==15 goes to CHECK if CHECKSUM_EN is defined, otherwise to RELEASE. wr_valid=0 stalls indefinitely.
  - CHECK: available only with CHECKSUM_EN; described under Optional Feature.
  - RELEASE: one cycle. wr_ready=0, cpu_n_reset=0, done=1. Next state IDLE, where cpu_n_reset<=1.
  - FAIL: available only with CHECKSUM_EN. cpu_n_reset=0, err=1, wr_ready=0. load_start -> LOAD (err<=0).
- load_start outside IDLE/FAIL is ignored.
- wr_valid outside LOAD is ignored and nothing is written.
- wr_ptr wraps 15->0 only by the state change; no 17th data write ever occurs.
- n_reset asserted mid-load:
  - Immediate return to reset values, and memory is cleared.
  - The partial program is discarded.
- The CPU sees at least 2 consecutive cycles of cpu_n_reset=0 per load: LOAD entry through RELEASE.

Optional Feature:
- Macro: TD4_PROG_MEM_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) of the 16 data bytes is kept, cleared on LOAD entry.
  - After word 15, state CHECK keeps wr_ready=1 and accepts one checksum byte.
  - If sum+checksum==8'h00 (mod 256): go to RELEASE.
  - Otherwise: go to FAIL. err=1 and the CPU stays held until the next load_start; memory keeps the bad contents.
- Undefined: no CHECK or FAIL state, no sum register, err tied to 0.

Decomposition:
- Shared package td4_pkg:
  - TD4_ADDR_W=4 and TD4_DATA_W=8.
  - Loader state enum: IDLE, LOAD, CHECK, RELEASE, FAIL.
  - TD4 opcode constants, also used by CPU benches.
- No sub-module; memory array, FSM and checksum accumulator stay in one module.

Test Plan:
- Reset then idle:
  - Stimulus: pulse n_reset low, address=0..15.
  - Response: instr=8'h00 for every address; cpu_n_reset=0 during reset and 1 one edge later; busy=0.
- Full load, back-to-back:
  - Stimulus: load_start, then the ramen-timer bytes B7,01,E1,01,E3,B6,01,E6,01,E8,B0,B4,01,EA,B8,FF with wr_valid held high. With CHECKSUM_EN, append F7.
  - Response: done pulses exactly once; address=0 -> instr=B7 and address=15 -> instr=FF; cpu_n_reset returns to 1 one cycle after done.
  - System check: CPU plus this block runs the program; CPU out matches the program's expected timer sequence.
- Stalled stream:
  - Stimulus: wr_valid toggled 1,0,0,1,... during the load.
  - Response: only handshaked bytes are written, in order; wr_ptr never skips; cpu_n_reset stays 0 for the whole load.
- Spurious inputs:
  - Stimulus: wr_valid=1, wr_data=AA in IDLE; load_start re-pulsed mid-LOAD.
  - Response: no memory change in IDLE; the load continues unaffected.
- Reset mid-load:
  - Stimulus: assert n_reset after 7 bytes.
  - Response: memory all 00, state IDLE, busy=0, cpu_n_reset=0 until the first edge after release.
- Checksum fail (CHECKSUM_EN defined):
  - Stimulus: the same 16 bytes with checksum 00.
  - Response: err=1, done never pulses, cpu_n_reset stays 0; a subsequent correct load clears err and pulses done.

Source files
------------

// File: rtl/td4_pkg.sv
// ============================================================================
// td4_pkg -- definitions shared across the TD4 CPU codebase.
//
// Contents:
//   TD4_ADDR_W / TD4_DATA_W  program address and instruction widths
//   load_state_t             program-loader state encoding
//   OP_*                     TD4 opcode constants ({op[3:0], im[3:0]} format)
//   td4_instr()              assemble one instruction byte from op and im
// ============================================================================
package td4_pkg;

    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;

    // Loader states. CHECK and FAIL are only reachable when the checksum
    // option is compiled in; the encoding is shared so benches agree on it.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RELEASE,
        FAIL
    } load_state_t;

    // TD4 opcodes: upper nibble of the instruction byte.
    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC_IM   = 4'b1110;
    localparam logic [3:0] OP_JMP_IM   = 4'b1111;

    function automatic logic [TD4_DATA_W-1:0] td4_instr(input logic [3:0] op,
                                                        input logic [3:0] im);
        return {op, im};
    endfunction

endpackage : td4_pkg

// File: rtl/td4_prog_mem.sv
// ============================================================================
// td4_prog_mem -- writable 16 x 8 program memory for the TD4 fetch port.
//
// The CPU reads instr = mem[address] combinationally at all times. A
// valid/ready byte stream refills all words (word 0 first). While a load is
// in flight the CPU is held in reset through cpu_n_reset; after the last
// byte the block pulses done and releases the CPU so it restarts at address
// 0 with the new program.
//
// Build option:
//   TD4_PROG_MEM_CHECKSUM_EN  After the 16 program bytes one checksum byte is
//                             accepted; the load succeeds only when the mod-256
//                             sum of all 17 bytes is zero. Otherwise the block
//                             parks in FAIL with err=1 and the CPU held until
//                             the next load_start. Without the option err is 0.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   n_reset      asynchronous active-low reset (also clears the memory)
//   address      CPU fetch address (program counter)
//   instr        instruction at address, combinational
//   load_start   single-cycle request to start a load (IDLE/FAIL only)
//   wr_valid     wr_data holds a program byte
//   wr_data      program byte
//   wr_ready     a byte is accepted this cycle when wr_valid is also high
//   cpu_n_reset  registered active-low reset to the CPU
//   busy         any loader state other than IDLE
//   done         one-cycle pulse on successful completion
//   err          sticky checksum failure
// ============================================================================
module td4_prog_mem
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              cpu_n_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    load_state_t       state;
    load_state_t       state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_fire;    // byte handshake this cycle (LOAD or CHECK)
    logic mem_we;     // handshake that carries a program word
    logic last_word;  // wr_ptr addresses the top word
    logic entering_load;

    assign wr_fire       = wr_valid && wr_ready;
    assign mem_we        = wr_fire && (state == LOAD);
    assign last_word     = &wr_ptr;
    assign entering_load = (state_d == LOAD) && (state != LOAD);

    // Read port: writes land at the edge and are visible right after it.
    assign instr = mem[address];

`ifdef TD4_PROG_MEM_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_chk;
    logic              sum_ok;

    // Program bytes plus the checksum byte must total zero mod 2**DATA_W.
    assign sum_chk = sum + wr_data;
    assign sum_ok  = (sum_chk == '0);
`endif

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: state_d is assigned before the case so every path drives it;
        // a missing default here would infer a latch.
        state_d = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // ptr wraps back to 0 with this beat; the state change is what
                // stops a 17th word from being written.
                if (mem_we && last_word) begin
`ifdef TD4_PROG_MEM_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = RELEASE;
`endif
                end
            end
`ifdef TD4_PROG_MEM_CHECKSUM_EN
            CHECK: begin
                if (wr_fire) begin
                    state_d = sum_ok ? RELEASE : FAIL;
                end
            end
            FAIL: begin
                if (load_start) begin
                    state_d = LOAD;
                end
            end
`endif
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, pointer and registered outputs. Outputs are decoded from the
    // state being entered so they line up with the state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            cpu_n_reset <= 1'b0;
            wr_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments so
            // every register here samples pre-edge values.
            state       <= state_d;
            cpu_n_reset <= (state_d == IDLE);
            wr_ready    <= (state_d == LOAD) || (state_d == CHECK);
            busy        <= (state_d != IDLE);
            done        <= (state_d == RELEASE);

            if (entering_load) begin
                wr_ptr <= '0;
            end else if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

`ifdef TD4_PROG_MEM_CHECKSUM_EN
    logic err_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else begin
            // err is set on the way into FAIL and cleared by the load_start
            // that leaves it, which is exactly "state is FAIL".
            err_q <= (state_d == FAIL);
            if (entering_load) begin
                sum <= '0;
            end else if (mem_we) begin
                sum <= sum + wr_data;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Program storage
    // ------------------------------------------------------------------------
    // NOTE: the array is built from resettable flops because n_reset must
    // discard a partial program; a RAM macro could not be cleared this way.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule : td4_prog_mem
